wbu: RTL
========

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC driven on npc_out while in and after reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port valid_in_lsu, input, 1, LSU result valid.
REQ-005 SHALL have port ready_out_lsu, output, 1, WBU can accept a result.
REQ-006 SHALL have inputs pc[31:0], alu_out[31:0], rdata[31:0] (processed load data), csr_out[31:0], opcode[6:0], ben, rd[4:0], gpr_wen, csr_wen, csr_waddr[11:0], csr_wdata[31:0], sys_jump (ecall/mret), all sampled from LSU.
REQ-007 SHALL have outputs gpr_we, gpr_waddr[4:0], gpr_wdata[31:0], the register-file write port.
REQ-008 SHALL have outputs csr_we, csr_waddr_o[11:0], csr_wdata_o[31:0], the CSR write port.
REQ-009 SHALL have outputs valid_out_ifu (1) and npc_out[31:0], the next fetch PC offered to IFU.
REQ-010 SHALL have input ready_in_ifu, 1, IFU accepts npc_out.
REQ-011 SHALL have output inst_cnt[31:0], count of committed instructions.

Function
REQ-012 SHALL implement states IDLE, COMMIT and NOTIFY in a registered FSM.
REQ-013 SHALL drive ready_out_lsu=1 only in IDLE.
REQ-014 SHALL, in IDLE with valid_in_lsu=1, capture all REQ-006 inputs into internal buffers and go to COMMIT; otherwise stay in IDLE.
REQ-015 SHALL hold COMMIT for exactly one cycle, then go to NOTIFY unconditionally.
REQ-016 SHALL stay in NOTIFY while ready_in_ifu=0, and go to IDLE on the cycle ready_in_ifu=1.
REQ-017 SHALL assert gpr_we only in COMMIT, equal to buffered gpr_wen AND (rd!=0); rd=0 never writes.
REQ-018 SHALL select gpr_wdata by buffered opcode: 0000011 (LOAD) -> rdata; 1101111/1100111 (JAL/JALR) -> pc+4; 1110011 (SYSTEM) -> csr_out; otherwise alu_out.
REQ-019 SHALL assert csr_we only in COMMIT, equal to buffered csr_wen, with csr_waddr_o/csr_wdata_o taken from the buffers.
REQ-020 SHALL compute npc with this priority:
- sys_jump -> csr_out
- JALR -> alu_out & ~32'h1
- JAL -> alu_out
- opcode 1100011 with ben=1 -> alu_out
- otherwise pc+4
REQ-021 SHALL register npc into npc_out in COMMIT and hold it stable through NOTIFY until the handshake completes.
REQ-022 SHALL assert valid_out_ifu only in NOTIFY; the IFU handshake completes on a cycle with valid_out_ifu=1 and ready_in_ifu=1.
REQ-023 SHALL increment inst_cnt by 1 in COMMIT, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 SHALL use 32-bit modulo arithmetic for pc+4, so 32'hFFFF_FFFC -> 0.
REQ-025 SHALL ignore valid_in_lsu outside IDLE: inputs are not sampled and no extra commit occurs.
REQ-026 SHALL give result-to-IFU latency of 2 cycles (accept edge -> COMMIT -> NOTIFY), and a minimum of 3 cycles per instruction.

Reset
REQ-027 SHALL, while rst=1 at a posedge, set state=IDLE, gpr_we=0, csr_we=0, valid_out_ifu=0, inst_cnt=0, npc_out=RESET_PC, and clear buffers to 0.
REQ-028 SHALL, on reset asserted in COMMIT or NOTIFY, abandon the instruction: no register-file or CSR write after the reset edge, and no IFU handshake.
REQ-029 SHALL drive ready_out_lsu=1 on the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover the ADDI path: opcode 0010011, rd=5, gpr_wen=1, alu_out=0x11, pc=0x80000000 -> gpr_we pulses 1 cycle with waddr=5, wdata=0x11; npc_out=0x80000004; inst_cnt=1.
REQ-031 SHALL cover LOAD to x0: opcode 0000011, rd=0, gpr_wen=1, rdata=0xDEADBEEF -> gpr_we stays 0; npc_out=pc+4.
REQ-032 SHALL cover branch and jump targets:
- BEQ, ben=1, alu_out=0x80000100 -> npc_out=0x80000100
- ben=0 -> npc_out=pc+4
- JALR, alu_out=0x80000203 -> npc_out=0x80000202, gpr_wdata=pc+4
REQ-033 SHALL cover ecall: sys_jump=1, csr_wen=1, csr_waddr=0x341, csr_wdata=pc, csr_out=0x80001000 -> csr_we pulses with addr 0x341; npc_out=0x80001000.
REQ-034 SHALL cover IFU back-pressure: ready_in_ifu=0 for 5 cycles -> valid_out_ifu and npc_out held stable, ready_out_lsu=0, and a valid_in_lsu pulse meanwhile is ignored (inst_cnt unchanged).
REQ-035 SHALL cover reset during NOTIFY: rst=1 for 1 cycle -> valid_out_ifu=0, npc_out=0x80000000, inst_cnt=0, ready_out_lsu=1 next cycle.

Source files
------------

// File: rtl/wbu.sv
// Write-back unit: buffers one LSU result, commits it to the GPR/CSR write ports, then offers the next PC to IFU.
// Latency: accept edge -> COMMIT (write ports active) -> NOTIFY (npc_out valid); at least 3 cycles per instruction.
// Backpressure: ready_out_lsu only in IDLE; NOTIFY holds valid_out_ifu/npc_out until ready_in_ifu.
module wbu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_lsu,
    output logic        ready_out_lsu,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] rdata,
    input  logic [31:0] csr_out,
    input  logic [6:0]  opcode,
    input  logic        ben,
    input  logic [4:0]  rd,
    input  logic        gpr_wen,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        sys_jump,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        valid_out_ifu,
    output logic [31:0] npc_out,
    input  logic        ready_in_ifu,
    output logic [31:0] inst_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        NOTIFY = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] rdata;
        logic [31:0] csr_out;
        logic [6:0]  opcode;
        logic        ben;
        logic [4:0]  rd;
        logic        gpr_wen;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        sys_jump;
    } wb_rec_t;

    state_t      state;
    wb_rec_t     wb_q;
    wb_rec_t     wb_d;
    logic [31:0] pc_plus4;
    logic [31:0] npc_nxt;
    logic [31:0] wdata_sel;

    always_comb begin
        wb_d           = '0;
        wb_d.pc        = pc;
        wb_d.alu_out   = alu_out;
        wb_d.rdata     = rdata;
        wb_d.csr_out   = csr_out;
        wb_d.opcode    = opcode;
        wb_d.ben       = ben;
        wb_d.rd        = rd;
        wb_d.gpr_wen   = gpr_wen;
        wb_d.csr_wen   = csr_wen;
        wb_d.csr_waddr = csr_waddr;
        wb_d.csr_wdata = csr_wdata;
        wb_d.sys_jump  = sys_jump;
    end

    assign pc_plus4 = wb_q.pc + 32'd4;

    // Trap/return target wins over any control-flow decode of the same instruction.
    always_comb begin
        npc_nxt = pc_plus4;
        if (wb_q.sys_jump)
            npc_nxt = wb_q.csr_out;
        else if (wb_q.opcode == OP_JALR)
            npc_nxt = wb_q.alu_out & ~32'h1;
        else if (wb_q.opcode == OP_JAL)
            npc_nxt = wb_q.alu_out;
        else if (wb_q.opcode == OP_BRANCH && wb_q.ben)
            npc_nxt = wb_q.alu_out;
    end

    always_comb begin
        wdata_sel = wb_q.alu_out;
        case (wb_q.opcode)
            OP_LOAD:          wdata_sel = wb_q.rdata;
            OP_JAL, OP_JALR:  wdata_sel = pc_plus4;
            OP_SYSTEM:        wdata_sel = wb_q.csr_out;
            default:          wdata_sel = wb_q.alu_out;
        endcase
    end

    assign gpr_waddr   = wb_q.rd;
    assign gpr_wdata   = wdata_sel;
    assign csr_waddr_o = wb_q.csr_waddr;
    assign csr_wdata_o = wb_q.csr_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wb_q          <= '0;
            ready_out_lsu <= 1'b1;
            gpr_we        <= 1'b0;
            csr_we        <= 1'b0;
            valid_out_ifu <= 1'b0;
            npc_out       <= RESET_PC;
            inst_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in_lsu) begin
                        wb_q          <= wb_d;
                        state         <= COMMIT;
                        ready_out_lsu <= 1'b0;
                        // Write enables are decoded from the incoming fields so they line up with COMMIT.
                        gpr_we        <= gpr_wen && (rd != 5'd0);
                        csr_we        <= csr_wen;
                    end
                end
                COMMIT: begin
                    state         <= NOTIFY;
                    gpr_we        <= 1'b0;
                    csr_we        <= 1'b0;
                    npc_out       <= npc_nxt;
                    inst_cnt      <= inst_cnt + 32'd1;
                    valid_out_ifu <= 1'b1;
                end
                NOTIFY: begin
                    if (ready_in_ifu) begin
                        state         <= IDLE;
                        valid_out_ifu <= 1'b0;
                        ready_out_lsu <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    ready_out_lsu <= 1'b1;
                    valid_out_ifu <= 1'b0;
                    gpr_we        <= 1'b0;
                    csr_we        <= 1'b0;
                end
            endcase
        end
    end

endmodule
